control_unit: RTL and testbench

Hardwired control sequencer for the 32-bit bus-based CPU datapath. It drives every datapath strobe: register in/out, MAR/MDR, IR, Y, Z, HI/LO, PC and memory read/write. It runs the fetch steps T0–T2 and the per-instruction execute steps T3–T7, so the datapath no longer needs bench-driven control waveforms. It sits beside `datapath` and reads the IR contents back from it.

---
 rtl/cpu_ctrl_pkg.sv | 53 +++++
 rtl/opcode_decode.sv | 30 +++
 rtl/control_unit.sv | 163 ++++++++++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer:
// opcodes, IR field positions, FSM states, instruction classes and the strobe bundle.
package cpu_ctrl_pkg;

   localparam int unsigned OP_W = 5;

   localparam int unsigned IR_OP_HI = 31;
   localparam int unsigned IR_OP_LO = 27;
   localparam int unsigned IR_RA_HI = 26;
   localparam int unsigned IR_RA_LO = 23;
   localparam int unsigned IR_RB_HI = 22;
   localparam int unsigned IR_RB_LO = 19;
   localparam int unsigned IR_RC_HI = 18;
   localparam int unsigned IR_RC_LO = 15;
   localparam int unsigned IR_C_HI  = 18;
   localparam int unsigned IR_C_LO  = 0;

   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
   localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   localparam logic [OP_W-1:0] ALU_ADD = 5'b00011;

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      CL_ALU_R, CL_ALU_I, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST,
      CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
   } iclass_t;

   typedef struct packed {
      logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, write;
      logic ir_in, y_in, zlo_in, zhi_in, zlo_out, zhi_out;
      logic lo_in, hi_in, lo_out, hi_out, c_out;
      logic gra, grb, grc, r_in, r_out, ba_out;
   } strobes_t;

endpackage

// File: rtl/opcode_decode.sv
// Maps a 5-bit opcode to the instruction class that selects the execute sequence.
module opcode_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [OP_W-1:0] i_opcode,
   output iclass_t         o_class
);

   always_comb begin
      o_class = CL_ILLEGAL;
      if (i_opcode >= OP_ADD && i_opcode <= OP_SHL) begin
         o_class = CL_ALU_R;
      end else begin
         case (i_opcode)
            OP_LD:                    o_class = CL_LD;
            OP_LDI:                   o_class = CL_LDI;
            OP_ST:                    o_class = CL_ST;
            OP_ADDI, OP_ANDI, OP_ORI: o_class = CL_ALU_I;
            OP_DIV, OP_MUL:           o_class = CL_MULDIV;
            OP_NEG, OP_NOT:           o_class = CL_UNARY;
            OP_MFHI:                  o_class = CL_MFHI;
            OP_MFLO:                  o_class = CL_MFLO;
            OP_NOP:                   o_class = CL_NOP;
            OP_HALT:                  o_class = CL_HALT;
            default:                  o_class = CL_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, execute T3-T7, Moore decode of
// datapath strobes from the registered state and the IR opcode.
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
   output logic ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin, LOout, HIout, Cout,
   output logic Gra, Grb, Grc, Rin, Rout, BAout,
   output logic [4:0]  alu_op,
   output logic        run,
   output logic        illegal
);

   state_t          r_state;
   iclass_t         w_class;
   strobes_t        w_s;
   logic [OP_W-1:0] w_opcode;
   logic            w_unused_ir;

   assign w_opcode    = ir[IR_OP_HI:IR_OP_LO];
   assign w_unused_ir = ^ir[IR_RA_HI:0];

   opcode_decode u_dec (.i_opcode(w_opcode), .o_class(w_class));

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state <= S_RESET;
      end else begin
         case (r_state)
            S_RESET: r_state <= S_T0;
            S_T0:    r_state <= S_T1;
            S_T1:    if (mem_ready) r_state <= S_T2;
            S_T2: begin
               case (w_class)
                  CL_NOP, CL_ILLEGAL: r_state <= S_T0;
                  CL_HALT:            r_state <= S_HALT;
                  default:            r_state <= S_T3;
               endcase
            end
            S_T3: r_state <= (w_class == CL_MFHI || w_class == CL_MFLO) ? S_T0 : S_T4;
            S_T4: r_state <= (w_class == CL_UNARY) ? S_T0 : S_T5;
            S_T5: begin
               case (w_class)
                  CL_MULDIV, CL_LD, CL_ST: r_state <= S_T6;
                  default:                 r_state <= S_T0;
               endcase
            end
            S_T6: begin
               case (w_class)
                  CL_ST:   r_state <= S_T7;
                  CL_LD:   if (mem_ready) r_state <= S_T7;
                  default: r_state <= S_T0;
               endcase
            end
            S_T7: begin
               // st waits for the write to complete; ld already waited in T6
               if (w_class != CL_ST || mem_ready) r_state <= S_T0;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_RESET;
         endcase
      end
   end

   always_comb begin
      w_s     = '0;
      alu_op  = '0;
      illegal = 1'b0;
      case (r_state)
         S_T0: begin w_s.pc_out = 1'b1; w_s.mar_in = 1'b1; w_s.inc_pc = 1'b1; w_s.zlo_in = 1'b1; end
         S_T1: begin w_s.zlo_out = 1'b1; w_s.pc_in = 1'b1; w_s.read = 1'b1; w_s.mdr_in = 1'b1; end
         S_T2: begin
            w_s.mdr_out = 1'b1; w_s.ir_in = 1'b1;
            illegal = (w_class == CL_ILLEGAL);
         end
         S_T3: begin
            case (w_class)
               CL_ALU_R, CL_ALU_I: begin w_s.grb = 1'b1; w_s.r_out = 1'b1; w_s.y_in = 1'b1; end
               CL_MULDIV: begin w_s.gra = 1'b1; w_s.r_out = 1'b1; w_s.y_in = 1'b1; end
               CL_UNARY: begin
                  w_s.grb = 1'b1; w_s.r_out = 1'b1; w_s.zlo_in = 1'b1; alu_op = w_opcode;
               end
               CL_LD, CL_LDI, CL_ST: begin w_s.grb = 1'b1; w_s.ba_out = 1'b1; w_s.y_in = 1'b1; end
               CL_MFHI: begin w_s.hi_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1; end
               CL_MFLO: begin w_s.lo_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (w_class)
               CL_ALU_R: begin
                  w_s.grc = 1'b1; w_s.r_out = 1'b1; w_s.zlo_in = 1'b1; alu_op = w_opcode;
               end
               CL_ALU_I: begin w_s.c_out = 1'b1; w_s.zlo_in = 1'b1; alu_op = w_opcode; end
               CL_MULDIV: begin
                  w_s.grb = 1'b1; w_s.r_out = 1'b1; w_s.zlo_in = 1'b1; w_s.zhi_in = 1'b1;
                  alu_op = w_opcode;
               end
               CL_UNARY: begin w_s.zlo_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1; end
               CL_LD, CL_LDI, CL_ST: begin w_s.c_out = 1'b1; w_s.zlo_in = 1'b1; alu_op = ALU_ADD; end
               default: ;
            endcase
         end
         S_T5: begin
            case (w_class)
               CL_ALU_R, CL_ALU_I, CL_LDI: begin w_s.zlo_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1; end
               CL_MULDIV:   begin w_s.zlo_out = 1'b1; w_s.lo_in = 1'b1; end
               CL_LD, CL_ST: begin w_s.zlo_out = 1'b1; w_s.mar_in = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            case (w_class)
               CL_MULDIV: begin w_s.zhi_out = 1'b1; w_s.hi_in = 1'b1; end
               CL_LD:     begin w_s.read = 1'b1; w_s.mdr_in = 1'b1; end
               CL_ST:     begin w_s.gra = 1'b1; w_s.r_out = 1'b1; w_s.mdr_in = 1'b1; end
               default: ;
            endcase
         end
         S_T7: begin
            case (w_class)
               CL_LD:   begin w_s.mdr_out = 1'b1; w_s.gra = 1'b1; w_s.r_in = 1'b1; end
               CL_ST:   w_s.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign run = (r_state != S_RESET) && (r_state != S_HALT);

   assign PCout    = w_s.pc_out;
   assign PCin     = w_s.pc_in;
   assign IncPC    = w_s.inc_pc;
   assign MARin    = w_s.mar_in;
   assign MDRin    = w_s.mdr_in;
   assign MDRout   = w_s.mdr_out;
   assign Read     = w_s.read;
   assign Write    = w_s.write;
   assign IRin     = w_s.ir_in;
   assign Yin      = w_s.y_in;
   assign ZLowIn   = w_s.zlo_in;
   assign ZHighIn  = w_s.zhi_in;
   assign ZLowOut  = w_s.zlo_out;
   assign ZHighOut = w_s.zhi_out;
   assign LOin     = w_s.lo_in;
   assign HIin     = w_s.hi_in;
   assign LOout    = w_s.lo_out;
   assign HIout    = w_s.hi_out;
   assign Cout     = w_s.c_out;
   assign Gra      = w_s.gra;
   assign Grb      = w_s.grb;
   assign Grc      = w_s.grc;
   assign Rin      = w_s.r_in;
   assign Rout     = w_s.r_out;
   assign BAout    = w_s.ba_out;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: step-by-step strobe, alu_op, run and
// illegal checks for each instruction class, memory waits, halt and mid-instruction reset.
module tb_control_unit;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic [31:0] ir = '0;
   logic        mem_ready = 1'b1;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
   logic ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin, LOout, HIout, Cout;
   logic Gra, Grb, Grc, Rin, Rout, BAout;
   logic [4:0] alu_op;
   logic       run, illegal;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [24:0] M_PCout = 25'h1000000, M_PCin = 25'h0800000, M_IncPC = 25'h0400000;
   localparam logic [24:0] M_MARin = 25'h0200000, M_MDRin = 25'h0100000, M_MDRout = 25'h0080000;
   localparam logic [24:0] M_Read = 25'h0040000, M_Write = 25'h0020000, M_IRin = 25'h0010000;
   localparam logic [24:0] M_Yin = 25'h0008000, M_ZLowIn = 25'h0004000, M_ZHighIn = 25'h0002000;
   localparam logic [24:0] M_ZLowOut = 25'h0001000, M_ZHighOut = 25'h0000800;
   localparam logic [24:0] M_LOin = 25'h0000400, M_HIin = 25'h0000200, M_LOout = 25'h0000100;
   localparam logic [24:0] M_HIout = 25'h0000080, M_Cout = 25'h0000040, M_Gra = 25'h0000020;
   localparam logic [24:0] M_Grb = 25'h0000010, M_Grc = 25'h0000008, M_Rin = 25'h0000004;
   localparam logic [24:0] M_Rout = 25'h0000002, M_BAout = 25'h0000001;

   localparam logic [24:0] F_T0 = M_PCout | M_MARin | M_IncPC | M_ZLowIn;
   localparam logic [24:0] F_T1 = M_ZLowOut | M_PCin | M_Read | M_MDRin;
   localparam logic [24:0] F_T2 = M_MDRout | M_IRin;

   logic [24:0] w_strb;
   assign w_strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
                    ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin, LOout, HIout, Cout,
                    Gra, Grb, Grc, Rin, Rout, BAout};

   control_unit dut (
      .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
      .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
      .LOin(LOin), .HIin(HIin), .LOout(LOout), .HIout(HIout), .Cout(Cout),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .alu_op(alu_op), .run(run), .illegal(illegal)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic outs(input string tag, input logic [24:0] s, input logic [4:0] a,
                       input bit chk_a, input logic r, input logic il);
      chk({tag, " strobes"}, {7'd0, w_strb}, {7'd0, s});
      if (chk_a) chk({tag, " alu_op"}, {27'd0, alu_op}, {27'd0, a});
      chk({tag, " run"}, {31'd0, run}, {31'd0, r});
      chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, il});
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic step(input string tag, input logic [24:0] s, input logic [4:0] a, input bit chk_a);
      outs(tag, s, a, chk_a, 1'b1, 1'b0);
      tick();
   endtask

   task automatic fetch(input string tag, input logic [31:0] ir_val, input logic ill, input int t1_waits);
      ir = ir_val;
      step({tag, " T0"}, F_T0, 5'd0, 1'b0);
      for (int i = 0; i < t1_waits; i++) begin
         mem_ready = 1'b0;
         step({tag, " T1 wait"}, F_T1, 5'd0, 1'b0);
      end
      mem_ready = 1'b1;
      step({tag, " T1"}, F_T1, 5'd0, 1'b0);
      outs({tag, " T2"}, F_T2, 5'd0, 1'b0, 1'b1, ill);
      tick();
   endtask

   initial begin
      // reset held: everything low
      repeat (2) tick();
      outs("reset", '0, 5'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      clear = 1'b1;
      #1;
      outs("reset exit", '0, 5'd0, 1'b1, 1'b0, 1'b0);
      @(posedge clock);
      #1;

      fetch("not", 32'h922B8000, 1'b0, 0);
      step("not T3", M_Grb | M_Rout | M_ZLowIn, 5'b10010, 1'b1);
      step("not T4", M_ZLowOut | M_Gra | M_Rin, 5'd0, 1'b0);

      fetch("add", 32'h18918000, 1'b0, 0);
      step("add T3", M_Grb | M_Rout | M_Yin, 5'd0, 1'b0);
      step("add T4", M_Grc | M_Rout | M_ZLowIn, 5'b00011, 1'b1);
      step("add T5", M_ZLowOut | M_Gra | M_Rin, 5'd0, 1'b0);

      fetch("addi", 32'h60000000, 1'b0, 0);
      step("addi T3", M_Grb | M_Rout | M_Yin, 5'd0, 1'b0);
      step("addi T4", M_Cout | M_ZLowIn, 5'b01100, 1'b1);
      step("addi T5", M_ZLowOut | M_Gra | M_Rin, 5'd0, 1'b0);

      fetch("mul", 32'h81A00000, 1'b0, 0);
      step("mul T3", M_Gra | M_Rout | M_Yin, 5'd0, 1'b0);
      step("mul T4", M_Grb | M_Rout | M_ZLowIn | M_ZHighIn, 5'b10000, 1'b1);
      step("mul T5", M_ZLowOut | M_LOin, 5'd0, 1'b0);
      step("mul T6", M_ZHighOut | M_HIin, 5'd0, 1'b0);

      fetch("ld", 32'h00900010, 1'b0, 0);
      step("ld T3", M_Grb | M_BAout | M_Yin, 5'd0, 1'b0);
      step("ld T4", M_Cout | M_ZLowIn, 5'b00011, 1'b1);
      step("ld T5", M_ZLowOut | M_MARin, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b0;
         step("ld T6 wait", M_Read | M_MDRin, 5'd0, 1'b0);
      end
      mem_ready = 1'b1;
      step("ld T6", M_Read | M_MDRin, 5'd0, 1'b0);
      step("ld T7", M_MDRout | M_Gra | M_Rin, 5'd0, 1'b0);

      fetch("st", 32'h10900004, 1'b0, 2);
      step("st T3", M_Grb | M_BAout | M_Yin, 5'd0, 1'b0);
      step("st T4", M_Cout | M_ZLowIn, 5'b00011, 1'b1);
      step("st T5", M_ZLowOut | M_MARin, 5'd0, 1'b0);
      mem_ready = 1'b0;
      step("st T6", M_Gra | M_Rout | M_MDRin, 5'd0, 1'b0);
      step("st T7 wait", M_Write, 5'd0, 1'b0);
      mem_ready = 1'b1;
      step("st T7", M_Write, 5'd0, 1'b0);

      fetch("ldi", 32'h08900003, 1'b0, 0);
      step("ldi T3", M_Grb | M_BAout | M_Yin, 5'd0, 1'b0);
      step("ldi T4", M_Cout | M_ZLowIn, 5'b00011, 1'b1);
      step("ldi T5", M_ZLowOut | M_Gra | M_Rin, 5'd0, 1'b0);

      fetch("mfhi", 32'hC0800000, 1'b0, 0);
      step("mfhi T3", M_HIout | M_Gra | M_Rin, 5'd0, 1'b0);
      fetch("mflo", 32'hC8800000, 1'b0, 0);
      step("mflo T3", M_LOout | M_Gra | M_Rin, 5'd0, 1'b0);

      fetch("nop", 32'hD0000000, 1'b0, 0);
      fetch("illegal", 32'hA0000000, 1'b1, 0);

      // clear mid-instruction during ld T5
      fetch("ld2", 32'h00900010, 1'b0, 0);
      step("ld2 T3", M_Grb | M_BAout | M_Yin, 5'd0, 1'b0);
      step("ld2 T4", M_Cout | M_ZLowIn, 5'b00011, 1'b1);
      outs("ld2 T5", M_ZLowOut | M_MARin, 5'd0, 1'b0, 1'b1, 1'b0);
      clear = 1'b0;
      #1;
      outs("ld2 clear", '0, 5'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1;

      fetch("halt", 32'hD8000000, 1'b0, 0);
      for (int i = 0; i < 20; i++) begin
         outs("halt hold", '0, 5'd0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock);
      #1;
      step("refetch T0", F_T0, 5'd0, 1'b0);
      step("refetch T1", F_T1, 5'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
